sort_rx_check: RTL
==================

Name: sort_rx_check

Overview:
- Receiving end of the sorter output stream.
- Captures one frame of K N-bit words delivered while `data_in_en` is high and checks that the frame is non-decreasing.
- Checks that the frame length equals K and tracks min/max.
- Holds the captured frame for random-access readback; sits between the sorter and the downstream consumer/test logic.

Parameters:
- N, 8, data word width in bits.
- K, 5, expected words per frame (K >= 2).
- AW, 3, readback address width; must satisfy 2^AW >= K.
- CW, 4, length counter width; must satisfy 2^CW > K+1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- data_in  in  N  stream word, valid when data_in_en=1.
- data_in_en  in  1  frame qualifier; high for the whole frame, one word per cycle.
- rd_en  in  1  readback request.
- rd_addr  in  AW  readback index.
- rd_data  out  N  readback word, registered.
- frame_done  out  1  one-cycle pulse at end of each frame.
- frame_ok  out  1  last frame had correct length and no order error.
- err_order  out  1  last frame had a word smaller than its predecessor.
- err_len  out  1  last frame length != K.
- min_val  out  N  first captured word of last frame.
- max_val  out  N  largest captured word of last frame.
- busy  out  1  frame capture in progress.

Behaviour:
- Reset (async, immediate): all outputs 0, state IDLE, length counter 0, capture buffer contents don't-care.
- Reset mid-frame aborts the frame with no frame_done and no flag update.
- States: IDLE, CAPT, DONE.
- IDLE:
  - data_in_en=1 -> store data_in at buf[0], prev<=data_in, cnt<=1, running max<=data_in, clear order-error accumulator, busy<=1 -> CAPT.
- CAPT:
  - data_in_en=1 -> if cnt<K store at buf[cnt]. Always compare data_in against prev; if data_in<prev set order accumulator. Update prev and running max. cnt saturates at K+1.
  - Equal consecutive words are legal.
  - Words beyond K are compared but not stored.
  - data_in_en=0 -> frame ended -> DONE; the word count is cnt.
- DONE (exactly one cycle):
  - frame_done=1, busy=0.
  - Latch err_len=(cnt!=K), err_order=accumulator, frame_ok=!(err_len|err_order), min_val=buf[0], max_val=running max.
  - If data_in_en=1 this cycle, it is the first word of the next frame (same actions as IDLE start) -> CAPT; else -> IDLE.
- Result outputs hold until the next DONE; they do not change during a new capture.
- Single-cycle frame (en high 1 cycle): cnt=1, err_len=1 unless K=1 (not allowed).
- Readback:
  - rd_data updates on the cycle after rd_en.
  - rd_data=buf[rd_addr] if rd_addr<K and busy=0; else 0.
  - rd_data holds when rd_en=0.
  - Reads during DONE return pre-update buffer contents for indices already written; no bypass.
- Short frame: buffer indices >= cnt keep stale data; the reader must consult err_len.
- Latency: frame_done occurs 1 cycle after data_in_en falls.

Decomposition:
- Shared package (sort_pkg) holds the state encodings IDLE/CAPT/DONE and default N, K so the sorter and this block agree.
- One natural sub-module: sort_rx_buf, a K x N register file with one write port and one registered read port.
- Length counter, compare and flags stay in the top level.

Test Plan:
- N=8, K=5, send 3,7,7,20,200 with en high 5 cycles -> frame_done pulse 1 cycle later; frame_ok=1, err_order=0, err_len=0, min_val=3, max_val=200; readback addr 0..4 returns 3,7,7,20,200.
- Send 3,9,4,10,11 -> err_order=1, frame_ok=0, err_len=0, max_val=11, min_val=3.
- Send 4 words 1,2,3,4 -> err_len=1, frame_ok=0. Send 6 words 1..6 -> err_len=1, max_val=6, addr 4 reads 5.
- Frame A (1..5), en low exactly one cycle, frame B (10..14) -> frame_done twice; during B's capture outputs still show A; after B min_val=10, max_val=14, frame_ok=1.
- Assert rst for 1 cycle mid-frame after 2 words -> all outputs 0 immediately, no frame_done; next full frame 5..9 is reported correctly.
- rd_en with rd_addr=6 (>=K), or while busy=1 -> rd_data=0 next cycle.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared definitions for the sorter and its receive-side checker.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package sort_pkg;

  localparam int SORT_N = 8;
  localparam int SORT_K = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    DONE = 2'd2
  } sort_rx_state_e;

endpackage

// File: rtl/sort_rx_check_if.sv
// Bundle of the sorter output stream, readback port and frame status.
// Latency: none, wiring only.
// Backpressure: none; the stream is qualifier-driven with no ready path.
interface sort_rx_check_if
  import sort_pkg::*;
#(
  parameter int N  = SORT_N,
  parameter int AW = 3
);
  logic [N-1:0]  data_in;
  logic          data_in_en;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [N-1:0]  rd_data;
  logic          frame_done;
  logic          frame_ok;
  logic          err_order;
  logic          err_len;
  logic [N-1:0]  min_val;
  logic [N-1:0]  max_val;
  logic          busy;

  modport master (
    output data_in, data_in_en, rd_en, rd_addr,
    input  rd_data, frame_done, frame_ok, err_order, err_len, min_val, max_val, busy
  );

  modport slave (
    input  data_in, data_in_en, rd_en, rd_addr,
    output rd_data, frame_done, frame_ok, err_order, err_len, min_val, max_val, busy
  );
endinterface

// File: rtl/sort_rx_buf.sv
// K x N capture register file, one write port, one registered read port.
// Latency: read data valid one cycle after i_re; writes visible next cycle.
// Backpressure: none; reads out of range or not permitted return zero.
module sort_rx_buf #(
  parameter int N  = 8,
  parameter int K  = 5,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [N-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  input  logic          i_rd_ok,
  output logic [N-1:0]  o_rdata
);
  localparam logic [AW:0] KA = (AW + 1)'(K);

  logic [N-1:0] r_mem [K];
  logic [N-1:0] r_rdata;

  // Storage array: contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (i_we && ({1'b0, i_waddr} < KA)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read; holds when no request, zero for invalid requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      if (i_rd_ok && ({1'b0, i_raddr} < KA)) begin
        r_rdata <= r_mem[i_raddr];
      end else begin
        r_rdata <= '0;
      end
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/sort_rx_check.sv
// Captures one sorter frame, checks order/length, tracks min/max, readback.
// Latency: frame_done one cycle after data_in_en falls; readback one cycle.
// Backpressure: none; a new frame may start in the DONE cycle itself.
module sort_rx_check
  import sort_pkg::*;
#(
  parameter int N  = SORT_N,
  parameter int K  = SORT_K,
  parameter int AW = 3,
  parameter int CW = 4
) (
  input logic           clk,
  input logic           rst,
  sort_rx_check_if.slave s_if
);
  localparam logic [CW-1:0] KC  = CW'(K);
  localparam logic [CW-1:0] KP1 = CW'(K + 1);

  sort_rx_state_e r_state, w_state_nxt;

  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_prev;
  logic [N-1:0]  r_run_max;
  logic [N-1:0]  r_first;
  logic          r_ord_acc;
  logic          r_busy;
  logic          r_frame_ok;
  logic          r_err_order;
  logic          r_err_len;
  logic [N-1:0]  r_min_val;
  logic [N-1:0]  r_max_val;

  logic          w_start;
  logic          w_capt;
  logic          w_end;
  logic          w_we;
  logic [AW-1:0] w_waddr;

  // A frame starts from IDLE or back-to-back from DONE.
  assign w_start = s_if.data_in_en && ((r_state == IDLE) || (r_state == DONE));
  assign w_capt  = s_if.data_in_en && (r_state == CAPT);
  assign w_end   = !s_if.data_in_en && (r_state == CAPT);

  // Words beyond K are still checked for order but never stored.
  assign w_we    = w_start || (w_capt && (r_cnt < KC));
  assign w_waddr = w_start ? '0 : AW'(r_cnt);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; DONE lasts exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = s_if.data_in_en ? CAPT : IDLE;
      CAPT:    w_state_nxt = s_if.data_in_en ? CAPT : DONE;
      DONE:    w_state_nxt = s_if.data_in_en ? CAPT : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture tracking, and result latching when the frame closes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_prev      <= '0;
      r_run_max   <= '0;
      r_first     <= '0;
      r_ord_acc   <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_err_order <= 1'b0;
      r_err_len   <= 1'b0;
      r_min_val   <= '0;
      r_max_val   <= '0;
    end else begin
      if (w_start) begin
        r_prev    <= s_if.data_in;
        r_run_max <= s_if.data_in;
        r_first   <= s_if.data_in;
        r_cnt     <= CW'(1);
        r_ord_acc <= 1'b0;
        r_busy    <= 1'b1;
      end
      if (w_capt) begin
        if (s_if.data_in < r_prev) begin
          r_ord_acc <= 1'b1;
        end
        if (s_if.data_in > r_run_max) begin
          r_run_max <= s_if.data_in;
        end
        r_prev <= s_if.data_in;
        if (r_cnt != KP1) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      if (w_end) begin
        r_busy      <= 1'b0;
        r_err_len   <= (r_cnt != KC);
        r_err_order <= r_ord_acc;
        r_frame_ok  <= !((r_cnt != KC) || r_ord_acc);
        // First captured word is buf[0]; kept in a register to leave the read port free.
        r_min_val   <= r_first;
        r_max_val   <= r_run_max;
      end
    end
  end

  sort_rx_buf #(
    .N (N),
    .K (K),
    .AW(AW)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_we),
    .i_waddr(w_waddr),
    .i_wdata(s_if.data_in),
    .i_re   (s_if.rd_en),
    .i_raddr(s_if.rd_addr),
    .i_rd_ok(!r_busy),
    .o_rdata(s_if.rd_data)
  );

  assign s_if.frame_done = (r_state == DONE);
  assign s_if.frame_ok   = r_frame_ok;
  assign s_if.err_order  = r_err_order;
  assign s_if.err_len    = r_err_len;
  assign s_if.min_val    = r_min_val;
  assign s_if.max_val    = r_max_val;
  assign s_if.busy       = r_busy;
endmodule
